// File: rtl/camera_packer.sv
// camera_packer: captures sensor frames (vsync/href) and packs PACK consecutive
// pixels per channel into one wide word per FIFO write, for CHANNELS channels.
// Optional build macro CAMERA_PACKER_TEST_PATTERN_EN replaces captured pixels
// with (column + line_count) on every channel; timing is unchanged.
// Handshake: wrreq is a one-cycle strobe qualifying wr_data; a word is only
// written when wr_full is low on the cycle it completes, otherwise it is
// dropped and overflow latches until the next frame start.
// state_dbg encoding: 0 IDLE, 1 WAIT_FRAME, 2 WAIT_LINE, 3 ACTIVE.
module camera_packer #(
    parameter int PIX_W        = 8,
    parameter int PACK         = 2,
    parameter int CHANNELS     = 3,
    parameter int IMAGE_WIDTH  = 512,
    parameter int IMAGE_HEIGHT = 512,
    parameter int CNT_W        = 12
) (
    input  logic                            pclk,
    input  logic                            reset,
    input  logic                            en_wr,
    input  logic                            vsync,
    input  logic                            href,
    input  logic [CHANNELS*PIX_W-1:0]       pix_data,
    input  logic                            wr_full,
    output logic [CHANNELS*PACK*PIX_W-1:0]  wr_data,
    output logic                            wrreq,
    output logic                            line_done,
    output logic                            frame_done,
    output logic                            overflow,
    output logic                            short_line,
    output logic [CNT_W-1:0]                line_count,
    output logic [1:0]                      state_dbg
);

    localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        WAIT_LINE  = 2'd2,
        ACTIVE     = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic                                   vsync_reg, href_reg;
    logic                                   vs_rise, href_rise;
    logic [CNT_W-1:0]                       pix_cnt, eff_cnt, line_count_inc;
    logic [LANE_W-1:0]                      lane_idx, eff_lane, lane_nxt;
    logic [CHANNELS-1:0][PACK-1:0][PIX_W-1:0] shadow, shadow_nxt;
    logic [CHANNELS-1:0][PIX_W-1:0]         pix_in;
    logic accept, word_done, line_end, short_end, frame_end, frame_start, abort;

    assign vs_rise        = vsync & ~vsync_reg;
    assign href_rise      = href & ~href_reg;
    assign line_count_inc = line_count + 1'b1;
    assign state_dbg      = state;

`ifdef CAMERA_PACKER_TEST_PATTERN_EN
    logic [CNT_W-1:0] column;
    logic [CNT_W-1:0] pattern_sum;

    // Synthetic pixel: column index within the line plus the line number.
    always_comb begin
        column      = CNT_W'(IMAGE_WIDTH) - eff_cnt;
        pattern_sum = column + line_count;
        for (int c = 0; c < CHANNELS; c++) begin
            pix_in[c] = PIX_W'(pattern_sum);
        end
    end
`else
    // Sensor pixel bus split into per-channel pixels.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            pix_in[c] = pix_data[c*PIX_W +: PIX_W];
        end
    end
`endif

    // Next-state logic plus the per-cycle capture/word/line events.
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        eff_cnt     = pix_cnt;
        eff_lane    = lane_idx;
        word_done   = 1'b0;
        line_end    = 1'b0;
        short_end   = 1'b0;
        frame_end   = 1'b0;
        frame_start = 1'b0;
        abort       = 1'b0;
        if (!en_wr) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: state_nxt = WAIT_FRAME;
                WAIT_FRAME: begin
                    if (vs_rise) begin
                        frame_start = 1'b1;
                        state_nxt   = WAIT_LINE;
                    end
                end
                WAIT_LINE: begin
                    if (vs_rise) begin
                        abort = 1'b1;
                    end else if (href_rise) begin
                        // The pixel on the rising-edge cycle is already valid.
                        accept    = 1'b1;
                        eff_cnt   = CNT_W'(IMAGE_WIDTH);
                        eff_lane  = '0;
                        state_nxt = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (vs_rise) begin
                        abort     = 1'b1;
                        state_nxt = WAIT_LINE;
                    end else if (href) begin
                        accept = 1'b1;
                    end else begin
                        // Line cut short: flush any partially filled word.
                        short_end = 1'b1;
                        line_end  = 1'b1;
                        word_done = (lane_idx != '0);
                    end
                end
                default: state_nxt = IDLE;
            endcase
            if (accept) begin
                word_done = (eff_lane == LANE_W'(PACK - 1)) || (eff_cnt == CNT_W'(1));
                line_end  = (eff_cnt == CNT_W'(1));
            end
            if (line_end) begin
                if (line_count_inc == CNT_W'(IMAGE_HEIGHT)) begin
                    frame_end = 1'b1;
                    state_nxt = WAIT_FRAME;
                end else begin
                    state_nxt = WAIT_LINE;
                end
            end
        end
    end

    // Shadow word assembly; lane 0 clears the word so unused lanes read as 0.
    always_comb begin
        lane_nxt   = (eff_lane == LANE_W'(PACK - 1)) ? '0 : eff_lane + 1'b1;
        shadow_nxt = shadow;
        if (accept) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (eff_lane == '0) begin
                    shadow_nxt[c] = '0;
                end
                shadow_nxt[c][eff_lane] = pix_in[c];
            end
        end
    end

    // State, counters, output strobes and sticky flags.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            vsync_reg  <= 1'b0;
            href_reg   <= 1'b0;
            pix_cnt    <= '0;
            lane_idx   <= '0;
            shadow     <= '0;
            wr_data    <= '0;
            wrreq      <= 1'b0;
            line_done  <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            short_line <= 1'b0;
            line_count <= '0;
        end else begin
            state      <= state_nxt;
            vsync_reg  <= vsync;
            href_reg   <= href;
            shadow     <= shadow_nxt;
            wrreq      <= word_done & ~wr_full;
            line_done  <= line_end;
            frame_done <= frame_end;
            if (word_done) begin
                wr_data <= shadow_nxt;
            end
            if (word_done && wr_full) begin
                overflow <= 1'b1;
            end else if (frame_start) begin
                overflow <= 1'b0;
            end
            if (short_end) begin
                short_line <= 1'b1;
            end else if (frame_start) begin
                short_line <= 1'b0;
            end
            if (frame_start || abort) begin
                line_count <= '0;
            end else if (line_end) begin
                line_count <= line_count_inc;
            end
            if (accept && state_nxt == ACTIVE) begin
                pix_cnt  <= eff_cnt - 1'b1;
                lane_idx <= lane_nxt;
            end else if (state_nxt != ACTIVE) begin
                pix_cnt  <= '0;
                lane_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_camera_packer.sv
// tb_camera_packer: randomized frames against a word-level reference model
// for camera_packer (PIX_W=8, PACK=2, CHANNELS=3, 4x2 image).
module tb_camera_packer;

    localparam int PIX_W = 8;
    localparam int PACK  = 2;
    localparam int CH    = 3;
    localparam int W     = 4;
    localparam int H     = 2;
    localparam int CNT_W = 12;
    localparam int DW    = CH * PACK * PIX_W;
    localparam int PW    = CH * PIX_W;
`ifdef CAMERA_PACKER_TEST_PATTERN_EN
    localparam bit PATTERN = 1'b1;
`else
    localparam bit PATTERN = 1'b0;
`endif

    logic             pclk = 1'b0;
    logic             reset = 1'b0;
    logic             en_wr = 1'b0;
    logic             vsync = 1'b0;
    logic             href = 1'b0;
    logic             wr_full = 1'b0;
    logic [PW-1:0]    pix_data = '0;
    logic [DW-1:0]    wr_data;
    logic             wrreq, line_done, frame_done, overflow, short_line;
    logic [CNT_W-1:0] line_count;
    logic [1:0]       state_dbg;

    // ---- clock ----
    always #5 pclk = ~pclk;

    camera_packer #(
        .PIX_W(PIX_W), .PACK(PACK), .CHANNELS(CH),
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .CNT_W(CNT_W)
    ) dut (
        .pclk(pclk), .reset(reset), .en_wr(en_wr), .vsync(vsync), .href(href),
        .pix_data(pix_data), .wr_full(wr_full), .wr_data(wr_data), .wrreq(wrreq),
        .line_done(line_done), .frame_done(frame_done), .overflow(overflow),
        .short_line(short_line), .line_count(line_count), .state_dbg(state_dbg)
    );

    // ---- scoreboard state ----
    int            n_vec = 0;
    int            n_miss = 0;
    logic [DW-1:0] exp_q[$];
    int            ld_cnt = 0;
    int            fd_cnt = 0;
    int            fd_alone = 0;
    int            got_cnt = 0;
    logic [PW-1:0] pix_mem [W];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference pixel for column idx of line line_no, channel c.
    function automatic logic [PIX_W-1:0] ref_pix(input int idx, input int line_no, input int c);
        return PATTERN ? PIX_W'(idx + line_no) : pix_mem[idx][c*PIX_W +: PIX_W];
    endfunction

    // Expected words for a line of n pixels; drop[w] marks words refused by wr_full.
    task automatic model_words(input int n, input int line_no, input logic [7:0] drop);
        logic [DW-1:0] word;
        int idx;
        for (int w = 0; w * PACK < n; w++) begin
            word = '0;
            for (int c = 0; c < CH; c++) begin
                for (int i = 0; i < PACK; i++) begin
                    idx = w * PACK + i;
                    if (idx < n) word[c*PACK*PIX_W + i*PIX_W +: PIX_W] = ref_pix(idx, line_no, c);
                end
            end
            if (!drop[w]) exp_q.push_back(word);
        end
    endtask

    // Output monitor, called once per cycle on the falling edge.
    task automatic sample();
        if (wrreq) begin
            got_cnt++;
            if (exp_q.size() == 0) chk("spurious_wrreq", 64'(wrreq), 64'd0);
            else chk("wr_data", 64'(wr_data), 64'(exp_q.pop_front()));
        end
        if (line_done) ld_cnt++;
        if (frame_done) begin
            fd_cnt++;
            if (!line_done) fd_alone++;
        end
    endtask

    // ---- driver tasks ----
    task automatic drive(input logic e, input logic v, input logic h,
                         input logic [PW-1:0] p, input logic f);
        en_wr = e; vsync = v; href = h; pix_data = p; wr_full = f;
        @(posedge pclk);
        @(negedge pclk);
        sample();
    endtask

    function automatic logic [PW-1:0] rnd_pix();
        return PW'($urandom);
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic fill_pix();
        for (int k = 0; k < W; k++) pix_mem[k] = rnd_pix();
    endtask

    task automatic start_frame();
        drive(1'b1, 1'b0, 1'b0, rnd_pix(), 1'b0);
        drive(1'b1, 1'b0, 1'b0, rnd_pix(), 1'b0);
        drive(1'b1, 1'b1, 1'b0, rnd_pix(), 1'b0);
        drive(1'b1, 1'b1, 1'b0, rnd_pix(), 1'b0);
        drive(1'b1, 1'b0, 1'b0, rnd_pix(), 1'b0);
    endtask

    // One line of n pixels from pix_mem, extra ignored href-high cycles, then href low.
    task automatic send_line(input int n, input int line_no, input logic [7:0] drop, input int extra);
        logic f;
        model_words(n, line_no, drop);
        for (int k = 0; k < n; k++) begin
            f = ((k % PACK == PACK - 1) || (k == W - 1)) ? drop[k / PACK] : rnd_bit();
            drive(1'b1, 1'b0, 1'b1, pix_mem[k], f);
        end
        for (int e = 0; e < extra; e++) drive(1'b1, 1'b0, 1'b1, rnd_pix(), rnd_bit());
        f = (n < W && n % PACK != 0) ? drop[n / PACK] : rnd_bit();
        drive(1'b1, 1'b0, 1'b0, rnd_pix(), f);
        drive(1'b1, 1'b0, 1'b0, rnd_pix(), 1'b0);
    endtask

    // ---- watchdog ----
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---- stimulus ----
    initial begin
        int ld0, fd0, got0, n;
        logic [7:0] drop;
        logic exp_ovf, exp_short;

        // reset
        repeat (3) @(negedge pclk);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_wrreq", 64'(wrreq), 64'd0);
        chk("rst_line_done", 64'(line_done), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_short_line", 64'(short_line), 64'd0);
        chk("rst_line_count", 64'(line_count), 64'd0);
        chk("rst_state", 64'(state_dbg), 64'd0);
        reset = 1'b1;

        // normal frame, R pixels 01..04 on line 0
        start_frame();
        ld0 = ld_cnt; fd0 = fd_cnt;
        fill_pix();
        for (int k = 0; k < W; k++) pix_mem[k][PIX_W-1:0] = PIX_W'(k + 1);
        send_line(W, 0, 8'd0, $urandom_range(0, 2));
        chk("n_line_done_l0", 64'(ld_cnt - ld0), 64'd1);
        chk("n_frame_done_l0", 64'(fd_cnt - fd0), 64'd0);
        chk("line_count_l0", 64'(line_count), 64'd1);
        fill_pix();
        send_line(W, 1, 8'd0, 0);
        chk("n_line_done_l1", 64'(ld_cnt - ld0), 64'd2);
        chk("n_frame_done", 64'(fd_cnt - fd0), 64'd1);
        chk("frame_without_line", 64'(fd_alone), 64'd0);
        chk("line_count_frame", 64'(line_count), 64'(H));
        chk("pending_words_s1", 64'(exp_q.size()), 64'd0);

        // overflow on second word of line 0, cleared by next vsync
        start_frame();
        fill_pix();
        send_line(W, 0, 8'b10, 0);
        chk("overflow_set", 64'(overflow), 64'd1);
        fill_pix();
        send_line(W, 1, 8'd0, 0);
        chk("overflow_sticky", 64'(overflow), 64'd1);
        start_frame();
        chk("overflow_cleared", 64'(overflow), 64'd0);
        chk("pending_words_s2", 64'(exp_q.size()), 64'd0);

        // short line R 0A 0B 0C
        ld0 = ld_cnt;
        fill_pix();
        pix_mem[0][PIX_W-1:0] = 8'h0A;
        pix_mem[1][PIX_W-1:0] = 8'h0B;
        pix_mem[2][PIX_W-1:0] = 8'h0C;
        send_line(3, 0, 8'd0, 0);
        chk("short_line_set", 64'(short_line), 64'd1);
        chk("short_line_done", 64'(ld_cnt - ld0), 64'd1);
        chk("short_line_count", 64'(line_count), 64'd1);
        chk("pending_words_s3", 64'(exp_q.size()), 64'd0);

        // vsync abort after one pixel
        fd0 = fd_cnt; got0 = got_cnt;
        drive(1'b1, 1'b0, 1'b1, rnd_pix(), 1'b0);
        drive(1'b1, 1'b1, 1'b1, rnd_pix(), 1'b0);
        drive(1'b1, 1'b1, 1'b0, rnd_pix(), 1'b0);
        drive(1'b1, 1'b0, 1'b0, rnd_pix(), 1'b0);
        chk("abort_line_count", 64'(line_count), 64'd0);
        chk("abort_no_words", 64'(got_cnt - got0), 64'd0);
        chk("abort_no_frame_done", 64'(fd_cnt - fd0), 64'd0);
        chk("abort_state", 64'(state_dbg), 64'd2);
        fill_pix();
        send_line(W, 0, 8'd0, 0);
        fill_pix();
        send_line(W, 1, 8'd0, 0);
        chk("abort_then_frame", 64'(fd_cnt - fd0), 64'd1);
        chk("abort_short_sticky", 64'(short_line), 64'd1);
        chk("pending_words_s4", 64'(exp_q.size()), 64'd0);

        // en_wr dropped mid-line, then a full frame
        start_frame();
        ld0 = ld_cnt; got0 = got_cnt;
        fill_pix();
        model_words(2, 0, 8'd0);
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b1, pix_mem[k], 1'b0);
        drive(1'b0, 1'b0, 1'b1, pix_mem[3], 1'b0);
        chk("disable_wrreq", 64'(wrreq), 64'd0);
        chk("disable_state", 64'(state_dbg), 64'd0);
        drive(1'b0, 1'b0, 1'b0, rnd_pix(), 1'b0);
        chk("disable_no_line_done", 64'(ld_cnt - ld0), 64'd0);
        start_frame();
        fill_pix();
        send_line(W, 0, 8'd0, 0);
        fill_pix();
        send_line(W, 1, 8'd0, 0);
        chk("reenable_words", 64'(got_cnt - got0), 64'd5);
        chk("pending_words_s5", 64'(exp_q.size()), 64'd0);

        // randomized frames
        for (int fr = 0; fr < 8; fr++) begin
            start_frame();
            fd0 = fd_cnt;
            exp_ovf = 1'b0;
            exp_short = 1'b0;
            for (int l = 0; l < H; l++) begin
                n = $urandom_range(1, W);
                drop = 8'($urandom_range(0, 3));
                if (n < W) exp_short = 1'b1;
                if ((drop & 8'((1 << ((n + PACK - 1) / PACK)) - 1)) != 8'd0) exp_ovf = 1'b1;
                fill_pix();
                send_line(n, l, drop, (n == W) ? $urandom_range(0, 2) : 0);
            end
            chk("rand_overflow", 64'(overflow), 64'(exp_ovf));
            chk("rand_short_line", 64'(short_line), 64'(exp_short));
            chk("rand_line_count", 64'(line_count), 64'(H));
            chk("rand_frame_done", 64'(fd_cnt - fd0), 64'd1);
            chk("rand_pending", 64'(exp_q.size()), 64'd0);
        end
        chk("frame_without_line_end", 64'(fd_alone), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
